// File: rtl/clcd_status_display.sv
// rtl/clcd_status_display.sv - character-LCD init/refresh sequencer for the elevator status panel
// Optional line-2 door display is enabled by defining CLCD_LINE2_EN.
module clcd_status_display #(
  parameter int unsigned      FLOOR_W = 4,
  parameter int unsigned      DLY_W   = 18,
  parameter logic [DLY_W-1:0] CMD_DLY = 18'h3FFFE,
  parameter logic [DLY_W-1:0] CLR_DLY = 18'h3FFFE
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [FLOOR_W-1:0] iFloor,
  input  logic [1:0]         iDir,
  input  logic               iDoor,
  input  logic               iDone,
  output logic               oStart,
  output logic [7:0]         oDATA,
  output logic               oRS,
  output logic               oReady,
  output logic               oBusy
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_REFRESH, S_LOAD, S_WAIT, S_DLY, S_NEXT} stateT;

  localparam logic [DLY_W-1:0] DLY_ONE = {{(DLY_W-1){1'b0}}, 1'b1};
`ifdef CLCD_LINE2_EN
  localparam logic [5:0] REF_LAST = 6'd33;
`else
  localparam logic [5:0] REF_LAST = 6'd16;
`endif

  stateT              state, stateNxt;
  logic [5:0]         idx, idxNxt, lastIdx;
  logic [DLY_W-1:0]   dlyCnt, cntNxt, dlyTarget;
  logic               initMode, initNxt, forceRef, forceNxt, pending, pendNxt, latchSnap;
  logic               startNxt, rsNxt, readyNxt, busyNxt, curRs, changed;
  logic [7:0]         dataNxt, curByte, tensCh, onesCh;
  logic [FLOOR_W-1:0] snapFloor;
  logic [1:0]         snapDir;
  logic [31:0]        dirStr;
  logic [127:0]       line1;
  logic [3:0]         charPos;
  int unsigned        flVal;

`ifdef CLCD_LINE2_EN
  logic         snapDoor;
  logic [127:0] line2;
  assign changed = (iFloor != snapFloor) || (iDir != snapDir) || (iDoor != snapDoor);
  assign line2   = {"DOOR ", (snapDoor ? "OPEN" : "CLSD"), "       "};
`else
  logic unusedDoor;
  assign unusedDoor = iDoor;
  assign changed    = (iFloor != snapFloor) || (iDir != snapDir);
`endif

  // Everything rendered comes from the snapshot so a refresh is internally consistent.
  always_comb begin
    flVal  = 32'(snapFloor);
    tensCh = 8'h20;
    onesCh = 8'h2D;
    if (flVal > 99) begin
      tensCh = 8'h2D;
    end else begin
      if (flVal >= 10) tensCh = 8'(32'd48 + flVal / 32'd10);
      onesCh = 8'(32'd48 + flVal % 32'd10);
    end
    case (snapDir)
      2'b00:   dirStr = "IDLE";
      2'b01:   dirStr = "UP  ";
      2'b10:   dirStr = "DOWN";
      default: dirStr = "----";
    endcase
    line1 = {"FLOOR ", tensCh, onesCh, "  ", dirStr, "  "};
  end

  always_comb begin
    curByte = 8'h00;
    curRs   = 1'b0;
    charPos = 4'd0;
    if (initMode) begin
      case (idx[1:0])
        2'd0:    curByte = 8'h38;
        2'd1:    curByte = 8'h0C;
        2'd2:    curByte = 8'h01;
        default: curByte = 8'h06;
      endcase
    end else if (idx == 6'd0) begin
      curByte = 8'h80;
    end else if (idx <= 6'd16) begin
      charPos = 4'(6'd16 - idx);
      curByte = line1[{charPos, 3'b000} +: 8];
      curRs   = 1'b1;
    end
`ifdef CLCD_LINE2_EN
    else if (idx == 6'd17) begin
      curByte = 8'hC0;
    end else begin
      charPos = 4'(6'd33 - idx);
      curByte = line2[{charPos, 3'b000} +: 8];
      curRs   = 1'b1;
    end
`endif
  end

  assign lastIdx   = initMode ? 6'd3 : REF_LAST;
  assign dlyTarget = (oDATA == 8'h01 && !oRS) ? CLR_DLY : CMD_DLY;

  always_comb begin
    stateNxt  = state;
    idxNxt    = idx;
    cntNxt    = dlyCnt;
    initNxt   = initMode;
    forceNxt  = forceRef;
    pendNxt   = pending;
    latchSnap = 1'b0;
    startNxt  = oStart;
    dataNxt   = oDATA;
    rsNxt     = oRS;
    readyNxt  = oReady;
    // Changes arriving mid-refresh collapse into a single follow-up refresh.
    if (!initMode && (state inside {S_LOAD, S_WAIT, S_DLY, S_NEXT}) && changed) pendNxt = 1'b1;
    case (state)
      S_INIT: begin
        initNxt  = 1'b1;
        idxNxt   = 6'd0;
        stateNxt = S_LOAD;
      end
      S_IDLE: if (forceRef || pending || changed) stateNxt = S_REFRESH;
      S_REFRESH: begin
        latchSnap = 1'b1;
        initNxt   = 1'b0;
        forceNxt  = 1'b0;
        pendNxt   = 1'b0;
        idxNxt    = 6'd0;
        stateNxt  = S_LOAD;
      end
      S_LOAD: begin
        startNxt = 1'b1;
        dataNxt  = curByte;
        rsNxt    = curRs;
        stateNxt = S_WAIT;
      end
      S_WAIT: if (iDone) begin
        startNxt = 1'b0;
        cntNxt   = '0;
        stateNxt = S_DLY;
      end
      S_DLY: begin
        if (dlyCnt == dlyTarget - DLY_ONE) stateNxt = S_NEXT;
        else cntNxt = dlyCnt + DLY_ONE;
      end
      S_NEXT: begin
        if (idx == lastIdx) begin
          idxNxt = 6'd0;
          if (initMode) begin
            readyNxt = 1'b1;
            stateNxt = S_IDLE;
          end else begin
            stateNxt = pending ? S_REFRESH : S_IDLE;
          end
        end else begin
          idxNxt   = idx + 6'd1;
          stateNxt = S_LOAD;
        end
      end
      default: stateNxt = S_INIT;
    endcase
    busyNxt = !(stateNxt == S_IDLE && readyNxt);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= S_INIT;
      idx       <= 6'd0;
      dlyCnt    <= '0;
      initMode  <= 1'b1;
      forceRef  <= 1'b1;
      pending   <= 1'b0;
      snapFloor <= '0;
      snapDir   <= 2'b00;
      oStart    <= 1'b0;
      oDATA     <= 8'h00;
      oRS       <= 1'b0;
      oReady    <= 1'b0;
      oBusy     <= 1'b0;
    end else begin
      state    <= stateNxt;
      idx      <= idxNxt;
      dlyCnt   <= cntNxt;
      initMode <= initNxt;
      forceRef <= forceNxt;
      pending  <= pendNxt;
      oStart   <= startNxt;
      oDATA    <= dataNxt;
      oRS      <= rsNxt;
      oReady   <= readyNxt;
      oBusy    <= busyNxt;
      if (latchSnap) begin
        snapFloor <= iFloor;
        snapDir   <= iDir;
      end
    end
  end

`ifdef CLCD_LINE2_EN
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) snapDoor <= 1'b0;
    else if (latchSnap) snapDoor <= iDoor;
  end
`endif

endmodule

// File: tb/tb_clcd_status_display.sv
// tb/tb_clcd_status_display.sv - scoreboard bench for clcd_status_display
// Expected byte streams come from a string-level model; a monitor pops them as the DUT presents bytes.
module tb_clcd_status_display;

  localparam int CMD = 4;
  localparam int CLR = 8;
`ifdef CLCD_LINE2_EN
  localparam bit LINE2 = 1'b1;
`else
  localparam bit LINE2 = 1'b0;
`endif

  logic       iCLK, iRST_N, iDoor, iDone;
  logic [6:0] iFloor;
  logic [1:0] iDir;
  logic       oStart, oRS, oReady, oBusy;
  logic [7:0] oDATA;

  typedef struct packed {logic rs; logic [7:0] data; logic first;} expT;
  expT expQ[$];

  int checks = 0, failures = 0;
  int cyc = 0, doneCyc = 0, bytesTotal = 0;
  bit spurEn = 0;
  int mFloor = 0, mDir = 0;
  bit mDoor = 0;

  clcd_status_display #(.FLOOR_W(7), .DLY_W(18), .CMD_DLY(18'd4), .CLR_DLY(18'd8)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iFloor(iFloor), .iDir(iDir), .iDoor(iDoor), .iDone(iDone),
    .oStart(oStart), .oDATA(oDATA), .oRS(oRS), .oReady(oReady), .oBusy(oBusy)
  );

  initial begin
    iCLK = 0;
    forever #5 iCLK = ~iCLK;
  end

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void pushByte(input bit rs, input logic [7:0] data, input bit first);
    expT e;
    e.rs = rs; e.data = data; e.first = first;
    expQ.push_back(e);
  endfunction

  function automatic void pushInit();
    pushByte(0, 8'h38, 1);
    pushByte(0, 8'h0C, 0);
    pushByte(0, 8'h01, 0);
    pushByte(0, 8'h06, 0);
  endfunction

  function automatic void pushRefresh(input int fl, input int dir, input bit door);
    string line, digits, dirS, doorS;
    mFloor = fl; mDir = dir; mDoor = door;
    if (fl > 99) digits = "--";
    else digits = $sformatf("%2d", fl);
    case (dir)
      0:       dirS = "IDLE";
      1:       dirS = "UP  ";
      2:       dirS = "DOWN";
      default: dirS = "----";
    endcase
    line = {"FLOOR ", digits, "  ", dirS, "  "};
    pushByte(0, 8'h80, 1);
    for (int i = 0; i < 16; i++) pushByte(1, line[i], 0);
    if (LINE2) begin
      doorS = door ? "OPEN" : "CLSD";
      line  = {"DOOR ", doorS, "       "};
      pushByte(0, 8'hC0, 0);
      for (int i = 0; i < 16; i++) pushByte(1, line[i], 0);
    end
  endfunction

  function automatic bit keyDiff(input int fl, input int dir, input bit door);
    return (fl != mFloor) || (dir != mDir) || (LINE2 && (door != mDoor));
  endfunction

  // Controller model: iDone pulses 3 clocks after oStart; optional stray pulses while no byte is pending.
  initial begin
    iDone = 0;
    forever begin
      @(negedge iCLK);
      iDone = 0;
      if (oStart) begin
        repeat (2) @(negedge iCLK);
        iDone   = 1;
        doneCyc = cyc + 1;
      end else if (spurEn && $urandom_range(0, 4) == 0) begin
        iDone = 1;
      end
    end
  end

  initial begin : monitor
    logic       prevStart;
    logic [8:0] held;
    expT        e, prev;
    prevStart = 0;
    held      = '0;
    prev      = '0;
    forever begin
      @(negedge iCLK);
      if (oStart && !prevStart) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected byte: actual rs=%0b data=%02h required none", oRS, oDATA);
        end else begin
          e = expQ.pop_front();
          check($sformatf("byte %0d", bytesTotal), {23'b0, oRS, oDATA}, {23'b0, e.rs, e.data});
          if (!e.first)
            check($sformatf("gap before byte %0d", bytesTotal), cyc - doneCyc,
                  (prev.data == 8'h01 && !prev.rs) ? CLR + 2 : CMD + 2);
          prev = e;
        end
        bytesTotal++;
        held = {oRS, oDATA};
      end else if (oStart && prevStart) begin
        check("stable while oStart", {23'b0, oRS, oDATA}, {23'b0, held});
      end
      prevStart = oStart;
    end
  end

  task automatic setIn(input int fl, input int dir, input bit door);
    @(negedge iCLK);
    iFloor = 7'(fl);
    iDir   = 2'(dir);
    iDoor  = door;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    repeat (3) @(negedge iCLK);
    while (oBusy && n < 3000) begin
      @(negedge iCLK);
      n++;
    end
    check($sformatf("%s idle", name), oBusy, 0);
    check($sformatf("%s drained", name), expQ.size(), 0);
  endtask

  task automatic waitBytes(input int target, input string name);
    int n = 0;
    while (bytesTotal < target && n < 1000) begin
      @(negedge iCLK);
      n++;
    end
    check($sformatf("%s byte wait", name), bytesTotal >= target, 1);
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    while (!oReady && n < 500) begin
      @(negedge iCLK);
      n++;
    end
    check($sformatf("%s ready", name), oReady, 1);
  endtask

  task automatic pendingCase(input int flA, input int dirA, input int flC, input int dirC, input bit door);
    int mark;
    setIn(flA, dirA, door);
    pushRefresh(flA, dirA, door);
    mark = bytesTotal;
    waitBytes(mark + 2, "pending start");
    setIn(flA, (dirA + 1) % 4, door);
    repeat (5) @(negedge iCLK);
    setIn(flC, dirC, door);
    pushRefresh(flC, dirC, door);
    waitIdle("pending");
  endtask

  initial begin : stimulus
    int fl, dir, mark;
    bit door;
    iRST_N = 0; iFloor = 7'd3; iDir = 2'b01; iDoor = 0;
    repeat (3) @(negedge iCLK);
    check("reset oStart", oStart, 0);
    check("reset oDATA", oDATA, 0);
    check("reset oRS", oRS, 0);
    check("reset oReady", oReady, 0);
    check("reset oBusy", oBusy, 0);
    pushInit();
    pushRefresh(3, 1, 0);
    iRST_N = 1;
    waitReady("power-up");
    waitIdle("power-up");

    setIn(12, 1, 0);
    pushRefresh(12, 1, 0);
    waitIdle("floor 12");
    repeat (40) @(negedge iCLK);

    setIn(12, 1, 1);
    if (keyDiff(12, 1, 1)) pushRefresh(12, 1, 1);
    waitIdle("door only");
    repeat (40) @(negedge iCLK);

    pendingCase(5, 1, 5, 0, mDoor);

    spurEn = 1;
    setIn(120, 3, mDoor);
    pushRefresh(120, 3, mDoor);
    waitIdle("floor 120");
    repeat (40) @(negedge iCLK);
    spurEn = 0;

    for (int it = 0; it < 8; it++) begin
      door = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        fl  = ($urandom_range(0, 3) == 0) ? mFloor : $urandom_range(0, 127);
        dir = ($urandom_range(0, 3) == 0) ? mDir : $urandom_range(0, 3);
        setIn(fl, dir, door);
        if (keyDiff(fl, dir, door)) pushRefresh(fl, dir, door);
        waitIdle($sformatf("random idle %0d", it));
        repeat (20) @(negedge iCLK);
      end else begin
        fl = (mFloor + 1 + $urandom_range(0, 60)) % 128;
        pendingCase(fl, $urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(0, 3), door);
      end
    end

    fl = (mFloor + 7) % 128;
    setIn(fl, 1, 1);
    pushRefresh(fl, 1, 1);
    mark = bytesTotal;
    waitBytes(mark + 10, "reset mid-refresh");
    @(negedge iCLK);
    #2 iRST_N = 0;
    #1;
    check("abort oStart", oStart, 0);
    check("abort oDATA", oDATA, 0);
    check("abort oRS", oRS, 0);
    check("abort oReady", oReady, 0);
    check("abort oBusy", oBusy, 0);
    expQ.delete();
    repeat (3) @(negedge iCLK);
    pushInit();
    pushRefresh(fl, 1, 1);
    iRST_N = 1;
    waitReady("re-init");
    waitIdle("re-init");

    repeat (20) @(negedge iCLK);
    check("final queue empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
